// File: rtl/mkmif_pkg.sv
// Shared encodings for the MKMIF burst core: op codes, 23K SRAM command bytes, FSM states.
package mkmif_pkg;

    localparam logic [1:0] OP_READ    = 2'd0;
    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_ZEROISE = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;

    localparam logic [7:0] CMD_READ         = 8'h03;
    localparam logic [7:0] CMD_WRITE        = 8'h02;
    localparam logic [7:0] CMD_WRMR         = 8'h01;
    localparam logic [7:0] SEQ_MODE_NO_HOLD = 8'h41;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StCmd,
        StAddr,
        StData,
        StGap,
        StFinish
    } state_e;

    // A zero divisor would stall the shifter forever; treat it as the fastest rate.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mkmif_spi_byte.sv
// Byte-level SPI mode-0 shifter: owns SCLK timing, MSB-first shift out and sample in.
module mkmif_spi_byte
    import mkmif_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs_en_i,
    input  logic        start_i,
    input  logic [7:0]  tx_byte_i,
    input  logic [15:0] divisor_i,
    input  logic        spi_do_i,
    output logic        sclk_o,
    output logic        cs_n_o,
    output logic        di_o,
    output logic        busy_o,
    output logic        byte_done_o,
    output logic [7:0]  rx_byte_o
);

    logic [15:0] div;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  sh_q;
    logic [7:0]  rx_q;
    logic        busy_q;
    logic        sclk_q;
    logic        di_q;
    logic        half_end;

    assign div      = eff_div(divisor_i);
    assign half_end = busy_q && (cnt_q >= div - 16'd1);

    // Asserted in the last clk of the byte so the core can chain the next start seamlessly.
    assign byte_done_o = half_end && sclk_q && (bit_q == 3'd7);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            rx_q   <= '0;
            busy_q <= 1'b0;
            sclk_q <= 1'b0;
            di_q   <= 1'b0;
        end else if (start_i) begin
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= tx_byte_i;
            di_q   <= tx_byte_i[7];
            busy_q <= 1'b1;
            sclk_q <= 1'b0;
        end else if (busy_q) begin
            if (half_end) begin
                cnt_q  <= '0;
                sclk_q <= ~sclk_q;
                if (!sclk_q) begin
                    rx_q <= {rx_q[6:0], spi_do_i};
                end else begin
                    bit_q <= bit_q + 3'd1;
                    sh_q  <= {sh_q[6:0], 1'b0};
                    di_q  <= sh_q[6];
                    if (bit_q == 3'd7) begin
                        busy_q <= 1'b0;
                    end
                end
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign sclk_o    = sclk_q;
    assign cs_n_o    = ~cs_en_i;
    assign di_o      = di_q;
    assign busy_o    = busy_q;
    assign rx_byte_o = rx_q;

endmodule

// File: rtl/mkmif_burst_core.sv
// MKMIF burst core: sequences INIT, CMD, ADDR and DATA bytes for a 23K serial SRAM in
// sequential mode, with streaming write/read words and a zero-fill operation.
module mkmif_burst_core
    import mkmif_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output logic                    spi_sclk,
    output logic                    spi_cs_n,
    input  logic                    spi_do,
    output logic                    spi_di,
    input  logic [15:0]             sclk_div,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [1:0]              op,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    rd_valid,
    output logic [8*DATA_BYTES-1:0] rd_data,
    output logic                    done,
    output logic                    error
);

    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned AB = ADDR_WIDTH / 8;

    state_e                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  words_q, words_d;
    logic [2:0]            idx_q, idx_d;
    logic [2:0]            rx_cnt_q, rx_cnt_d;
    logic [16:0]           gap_q, gap_d;
    logic [DW-1:0]         tx_word_q, tx_word_d;
    logic [DW-1:0]         rx_acc_q, rx_acc_d;
    logic [DW-1:0]         rd_data_q, rd_data_d;
    logic                  cs_q, cs_d;
    logic                  err_q, err_d;
    logic                  init_q, init_d;
    logic                  data_byte_q, data_byte_d;
    logic                  rd_valid_q, rd_valid_d;

    logic          start;
    logic [7:0]    tx_byte;
    logic          busy;
    logic          byte_done;
    logic [7:0]    rx_byte;
    logic          launch;
    logic          wr_take;
    logic [DW-1:0] rx_next;
    logic [16:0]   gap_last;

    mkmif_spi_byte u_spi_byte (
        .clk         (clk),
        .reset_n     (reset_n),
        .cs_en_i     (cs_q),
        .start_i     (start),
        .tx_byte_i   (tx_byte),
        .divisor_i   (sclk_div),
        .spi_do_i    (spi_do),
        .sclk_o      (spi_sclk),
        .cs_n_o      (spi_cs_n),
        .di_o        (spi_di),
        .busy_o      (busy),
        .byte_done_o (byte_done),
        .rx_byte_o   (rx_byte)
    );

    // Next byte may go out when the shifter is idle or finishing its current byte.
    assign launch   = cs_q && (!busy || byte_done);
    assign rx_next  = (rx_acc_q << 8) | DW'(rx_byte);
    assign gap_last = {eff_div(sclk_div), 1'b0} - 17'd1;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        words_d     = words_q;
        idx_d       = idx_q;
        rx_cnt_d    = rx_cnt_q;
        gap_d       = gap_q;
        tx_word_d   = tx_word_q;
        rx_acc_d    = rx_acc_q;
        rd_data_d   = rd_data_q;
        cs_d        = cs_q;
        err_d       = err_q;
        init_d      = init_q;
        data_byte_d = data_byte_q;
        rd_valid_d  = 1'b0;
        start       = 1'b0;
        tx_byte     = 8'h00;
        wr_take     = 1'b0;

        if (byte_done && data_byte_q && (op_q == OP_READ)) begin
            if (rx_cnt_q == 3'(DATA_BYTES - 1)) begin
                rd_data_d  = rx_next;
                rd_valid_d = 1'b1;
                rx_cnt_d   = '0;
            end else begin
                rx_acc_d = rx_next;
                rx_cnt_d = rx_cnt_q + 3'd1;
            end
        end

        unique case (state_q)
            StInit: begin
                if (!cs_q) begin
                    cs_d = 1'b1;
                end else if (launch) begin
                    if (idx_q == 3'd0) begin
                        start   = 1'b1;
                        tx_byte = CMD_WRMR;
                        idx_d   = 3'd1;
                    end else if (idx_q == 3'd1) begin
                        start   = 1'b1;
                        tx_byte = SEQ_MODE_NO_HOLD;
                        idx_d   = 3'd2;
                    end else begin
                        cs_d    = 1'b0;
                        gap_d   = '0;
                        init_d  = 1'b1;
                        state_d = StGap;
                    end
                end
            end
            StIdle: begin
                if (op_valid) begin
                    op_d     = op;
                    addr_d   = addr;
                    words_d  = len;
                    idx_d    = '0;
                    rx_cnt_d = '0;
                    rx_acc_d = '0;
                    if ((len == '0) || (op == OP_RSVD)) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else begin
                        err_d   = 1'b0;
                        cs_d    = 1'b1;
                        state_d = StCmd;
                    end
                end
            end
            StCmd: begin
                if (launch) begin
                    start   = 1'b1;
                    tx_byte = (op_q == OP_READ) ? CMD_READ : CMD_WRITE;
                    idx_d   = '0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (launch) begin
                    start   = 1'b1;
                    tx_byte = 8'(addr_q >> (8 * (AB - 1 - 32'(idx_q))));
                    if (idx_q == 3'(AB - 1)) begin
                        idx_d   = '0;
                        state_d = StData;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StData: begin
                if (launch) begin
                    if (words_q == '0) begin
                        cs_d    = 1'b0;
                        gap_d   = '0;
                        state_d = StGap;
                    end else begin
                        if (idx_q != 3'd0) begin
                            start     = 1'b1;
                            tx_byte   = tx_word_q[DW-1 -: 8];
                            tx_word_d = tx_word_q << 8;
                        end else if (op_q == OP_WRITE) begin
                            // Without a word the core holds CS low with SCLK parked.
                            if (wr_valid) begin
                                wr_take   = 1'b1;
                                start     = 1'b1;
                                tx_byte   = wr_data[DW-1 -: 8];
                                tx_word_d = wr_data << 8;
                            end
                        end else begin
                            start     = 1'b1;
                            tx_word_d = '0;
                        end
                        if (start) begin
                            if (idx_q == 3'(DATA_BYTES - 1)) begin
                                idx_d   = '0;
                                words_d = words_q - 1'b1;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                    end
                end
            end
            StGap: begin
                if (gap_q >= gap_last) begin
                    init_d  = 1'b0;
                    state_d = init_q ? StIdle : StFinish;
                end else begin
                    gap_d = gap_q + 17'd1;
                end
            end
            StFinish: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase

        if (start) begin
            data_byte_d = (state_q == StData);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StInit;
            op_q        <= OP_READ;
            addr_q      <= '0;
            words_q     <= '0;
            idx_q       <= '0;
            rx_cnt_q    <= '0;
            gap_q       <= '0;
            tx_word_q   <= '0;
            rx_acc_q    <= '0;
            rd_data_q   <= '0;
            cs_q        <= 1'b0;
            err_q       <= 1'b0;
            init_q      <= 1'b0;
            data_byte_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            idx_q       <= idx_d;
            rx_cnt_q    <= rx_cnt_d;
            gap_q       <= gap_d;
            tx_word_q   <= tx_word_d;
            rx_acc_q    <= rx_acc_d;
            rd_data_q   <= rd_data_d;
            cs_q        <= cs_d;
            err_q       <= err_d;
            init_q      <= init_d;
            data_byte_q <= data_byte_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign op_ready = (state_q == StIdle);
    assign done     = (state_q == StFinish);
    assign error    = done && err_q;
    assign wr_ready = wr_take;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mkmif_burst_core.sv
// Directed bench for mkmif_burst_core with a behavioural 23K-series SRAM slave.
module tb_mkmif_burst_core;

    localparam int DB = 4;
    localparam int AW = 16;
    localparam int LW = 8;
    localparam int AB = AW / 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spi_sclk, spi_cs_n, spi_di;
    logic          spi_do = 1'b0;
    logic [15:0]   sclk_div = 16'd2;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [1:0]    op = 2'd0;
    logic [AW-1:0] addr = '0;
    logic [LW-1:0] len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [31:0]   wr_data;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic          done, error;

    always #5 clk = ~clk;

    mkmif_burst_core #(
        .DATA_BYTES (DB),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_do   (spi_do),
        .spi_di   (spi_di),
        .sclk_div (sclk_div),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .addr     (addr),
        .len      (len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .done     (done),
        .error    (error)
    );

    // SRAM slave model, edge-detected on the falling clk edge.
    logic [7:0]  mem [0:65535];
    logic [7:0]  frame_q [$];
    logic [7:0]  sh = '0, mcmd = '0;
    logic [15:0] maddr = '0;
    logic        sclk_prev = 1'b0, cs_prev = 1'b1;
    int          bitcnt = 0, rises = 0, mb = 0, cs_falls = 0, cs_hi_run = 0;

    always @(negedge clk) begin
        if (spi_cs_n) cs_hi_run++;
        else cs_hi_run = 0;
        if (!spi_cs_n && cs_prev) begin
            bitcnt = 0;
            rises = 0;
            mcmd = 8'h00;
            frame_q.delete();
            cs_falls++;
        end
        if (!spi_cs_n && spi_sclk && !sclk_prev) begin
            sh = {sh[6:0], spi_di};
            bitcnt++;
            rises++;
            if (bitcnt % 8 == 0) begin
                mb = bitcnt / 8 - 1;
                frame_q.push_back(sh);
                if (mb == 0) mcmd = sh;
                else if (mb <= AB) maddr = {maddr[7:0], sh};
                else if (mcmd == 8'h02) mem[16'(int'(maddr) + mb - 1 - AB)] = sh;
            end
        end
        if (!spi_cs_n && !spi_sclk && sclk_prev && mcmd == 8'h03 && bitcnt >= 8 * (1 + AB))
            spi_do = mem[16'(int'(maddr) + (bitcnt - 8 * (1 + AB)) / 8)]
                        [7 - ((bitcnt - 8 * (1 + AB)) % 8)];
        sclk_prev = spi_sclk;
        cs_prev = spi_cs_n;
    end

    logic [31:0] wr_words [0:3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hCAFEF00D};
    logic [1:0]  wr_cnt = 2'd0;
    int          wr_pulses = 0, rd_cnt = 0;
    logic [31:0] rd_last = '0;
    assign wr_data = wr_words[wr_cnt];

    always @(posedge clk) begin
        if (rd_valid) begin
            rd_cnt  <= rd_cnt + 1;
            rd_last <= rd_data;
        end
        if (wr_ready) begin
            wr_cnt    <= wr_cnt + 2'd1;
            wr_pulses <= wr_pulses + 1;
        end
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!op_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) check(tag, op_ready, 1'b1);
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [7:0] l);
        @(negedge clk);
        op = o;
        addr = a;
        len = l;
        op_valid = 1'b1;
        wait_ready("accept_timeout");
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!done && guard < 20000) begin
            @(posedge clk);
            #1 guard++;
        end
        if (guard >= 20000) check("done_timeout", done, 1'b1);
    endtask

    int w0, r0, r1, cf0, guard;
    logic stall_ok;

    initial begin
        mem[16'h0100] = 8'hDE; mem[16'h0101] = 8'hAD;
        mem[16'h0102] = 8'hBE; mem[16'h0103] = 8'hEF;
        for (int i = 0; i < 32; i++) mem[16'h0200 + i] = 8'(8'h10 + i);

        repeat (3) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sclk", spi_sclk, 1'b0);
        check("rst_di", spi_di, 1'b0);
        check("rst_op_ready", op_ready, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);

        reset_n = 1'b1;
        @(negedge clk);
        wait_ready("init_timeout");
        check("init_nbytes", frame_q.size(), 2);
        check("init_byte0", frame_q[0], 8'h01);
        check("init_byte1", frame_q[1], 8'h41);
        check("init_sclks", rises, 16);
        check("init_deselect", cs_hi_run >= 4, 1'b1);

        // Single-word read.
        r0 = rd_cnt;
        issue(2'd0, 16'h0100, 8'd1);
        wait_done();
        check("rd_error", error, 1'b0);
        check("rd_count", rd_cnt - r0, 1);
        check("rd_data", rd_last, 32'hDEADBEEF);
        check("rd_cmd", frame_q[0], 8'h03);
        check("rd_addr_hi", frame_q[1], 8'h01);
        check("rd_addr_lo", frame_q[2], 8'h00);
        check("rd_sclks", rises, 56);

        // Three-word write with a stall before the last word.
        w0 = wr_pulses;
        wr_valid = 1'b1;
        issue(2'd1, 16'h1FFC, 8'd3);
        guard = 0;
        while (wr_cnt != 2'd2 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        wr_valid = 1'b0;
        repeat (200) @(negedge clk);
        stall_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (spi_sclk !== 1'b0 || spi_cs_n !== 1'b0) stall_ok = 1'b0;
        end
        check("wr_stall_frozen", stall_ok, 1'b1);
        check("wr_stall_pulses", wr_pulses - w0, 2);
        wr_valid = 1'b1;
        wait_done();
        check("wr_pulses", wr_pulses - w0, 3);
        check("wr_cmd", frame_q[0], 8'h02);
        check("wr_addr_hi", frame_q[1], 8'h1F);
        check("wr_addr_lo", frame_q[2], 8'hFC);
        check("wr_mem0", {mem[16'h1FFC], mem[16'h1FFD], mem[16'h1FFE], mem[16'h1FFF]}, 32'h11223344);
        check("wr_mem1", {mem[16'h2000], mem[16'h2001], mem[16'h2002], mem[16'h2003]}, 32'h55667788);
        check("wr_mem2", {mem[16'h2004], mem[16'h2005], mem[16'h2006], mem[16'h2007]}, 32'h99AABBCC);

        // Zeroise over preloaded memory, with wr_valid left high.
        for (int i = 0; i < 16; i++) mem[i] = 8'hA5;
        w0 = wr_pulses;
        issue(2'd2, 16'h0000, 8'd4);
        wait_done();
        check("zero_error", error, 1'b0);
        check("zero_wr_ready", wr_pulses - w0, 0);
        check("zero_sclks", rises, 8 * (1 + AB + 16));
        for (int k = 0; k < 4; k++)
            check("zero_mem", {mem[4*k], mem[4*k+1], mem[4*k+2], mem[4*k+3]}, 32'h0);

        // Rejected ops: no SPI activity, done and error one cycle after acceptance.
        cf0 = cs_falls;
        issue(2'd0, 16'h0040, 8'd0);
        check("rej_len0_done", done, 1'b1);
        check("rej_len0_error", error, 1'b1);
        @(posedge clk);
        #1 check("rej_len0_done_pulse", done, 1'b0);
        issue(2'd3, 16'h0040, 8'd1);
        check("rej_op3_done", done, 1'b1);
        check("rej_op3_error", error, 1'b1);
        repeat (4) @(negedge clk);
        check("rej_no_cs", cs_falls - cf0, 0);

        // Reset in the middle of an 8-word read.
        r0 = rd_cnt;
        issue(2'd0, 16'h0200, 8'd8);
        guard = 0;
        while (rd_cnt < r0 + 2 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("mid_word1", rd_last, 32'h14151617);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_cs_n", spi_cs_n, 1'b1);
        check("mid_rst_sclk", spi_sclk, 1'b0);
        r1 = rd_cnt;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wait_ready("reinit_timeout");
        check("reinit_nbytes", frame_q.size(), 2);
        check("reinit_byte0", frame_q[0], 8'h01);
        check("reinit_byte1", frame_q[1], 8'h41);
        check("reinit_no_rd", rd_cnt - r1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
